// File: rtl/tec8_datapath_sequencer_if.sv
// rtl/tec8_datapath_sequencer_if.sv - control word in, status and display out, between controller and datapath
interface tec8_datapath_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              START;
  logic [7:0]        SD;
  logic              SELCTL, DRW, LPC, PCINC, PCADD, LAR, ARINC, LIR, LDZ, LDC;
  logic              CIN, M, MEMW, ABUS, SBUS, MBUS, STOP, SHORT, LONG;
  logic [3:0]        S;
  logic [3:0]        SEL;

  logic [2:0]        W;
  logic [3:0]        IR;
  logic              C;
  logic              Z;
  logic [7:0]        IR_FULL;
  logic [ADDR_W-1:0] PC_OUT;
  logic [ADDR_W-1:0] AR_OUT;
  logic [7:0]        DBUS;
  logic [7:0]        A_OUT;
  logic [7:0]        B_OUT;
  logic              RUN;

  modport master (
    output START, SD, SELCTL, DRW, LPC, PCINC, PCADD, LAR, ARINC, LIR, LDZ, LDC,
           CIN, M, MEMW, ABUS, SBUS, MBUS, STOP, SHORT, LONG, S, SEL,
    input  W, IR, C, Z, IR_FULL, PC_OUT, AR_OUT, DBUS, A_OUT, B_OUT, RUN
  );

  modport slave (
    input  START, SD, SELCTL, DRW, LPC, PCINC, PCADD, LAR, ARINC, LIR, LDZ, LDC,
           CIN, M, MEMW, ABUS, SBUS, MBUS, STOP, SHORT, LONG, S, SEL,
    output W, IR, C, Z, IR_FULL, PC_OUT, AR_OUT, DBUS, A_OUT, B_OUT, RUN
  );
endinterface

// File: rtl/tec8_datapath_sequencer.sv
// rtl/tec8_datapath_sequencer.sv - TEC-8 execution half: registers, ALU, bus, memory, W1/W2/W3 beat sequencer
module tec8_datapath_sequencer #(
  parameter int ADDR_W = 8
) (
  input  logic                          T3,
  input  logic                          CLR,
  tec8_datapath_sequencer_if.slave      bus
);

  localparam logic [2:0] W1 = 3'b001;
  localparam logic [2:0] W2 = 3'b010;
  localparam logic [2:0] W3 = 3'b100;
  localparam int         DEPTH = 2 ** ADDR_W;

  logic [7:0]        r_q [4];
  logic [7:0]        r_d [4];
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ar_q, ar_d;
  logic [7:0]        ir_q, ir_d;
  logic              c_q, c_d;
  logic              z_q, z_d;
  logic [2:0]        w_q, w_d;
  logic              run_q, run_d;

  logic [7:0]        mem_q [DEPTH];

  logic [1:0]        a_idx;
  logic [1:0]        b_idx;
  logic [7:0]        a_val;
  logic [7:0]        b_val;
  logic [7:0]        alu_f;
  logic              alu_cout;
  logic [7:0]        arith_y;
  logic [8:0]        arith_sum;
  logic [7:0]        dbus;
  logic [7:0]        mem_at_ar;
  logic [7:0]        mem_at_pc;
  logic [ADDR_W-1:0] pc_offset;

  // Console select overrides the instruction's register fields.
  assign a_idx = bus.SELCTL ? bus.SEL[3:2] : ir_q[3:2];
  assign b_idx = bus.SELCTL ? bus.SEL[1:0] : ir_q[1:0];
  assign a_val = r_q[a_idx];
  assign b_val = r_q[b_idx];

  assign mem_at_ar = mem_q[ar_q];
  assign mem_at_pc = mem_q[pc_q];

  always_comb begin
    arith_y = 8'h00;
    case (bus.S)
      4'b1001: arith_y = b_val;
      4'b0110: arith_y = ~b_val;
      4'b0000: arith_y = 8'h00;
      4'b1111: arith_y = 8'hFF;
      default: arith_y = 8'h00;
    endcase
  end

  // 74181 carry input is active-low: CIN=0 injects a carry.
  assign arith_sum = {1'b0, a_val} + {1'b0, arith_y} + {8'h00, ~bus.CIN};

  always_comb begin
    alu_f    = 8'h00;
    alu_cout = 1'b0;
    if (bus.M) begin
      case (bus.S)
        4'b1011: alu_f = a_val & b_val;
        4'b1010: alu_f = b_val;
        4'b1111: alu_f = a_val;
        4'b1110: alu_f = a_val | b_val;
        4'b0110: alu_f = a_val ^ b_val;
        4'b0000: alu_f = ~a_val;
        default: alu_f = 8'h00;
      endcase
    end else begin
      alu_f    = arith_sum[7:0];
      alu_cout = arith_sum[8];
    end
  end

  always_comb begin
    dbus = 8'h00;
    if (bus.MBUS)      dbus = mem_at_ar;
    else if (bus.ABUS) dbus = alu_f;
    else if (bus.SBUS) dbus = bus.SD;
  end

  assign pc_offset = {{(ADDR_W-4){ir_q[3]}}, ir_q[3:0]};

  always_comb begin
    r_d   = r_q;
    pc_d  = pc_q;
    ar_d  = ar_q;
    ir_d  = ir_q;
    c_d   = c_q;
    z_d   = z_q;
    w_d   = w_q;
    run_d = run_q;
    if (!run_q) begin
      // The start edge only arms the sequencer; nothing else moves.
      if (bus.START) run_d = 1'b1;
    end else begin
      case (w_q)
        W1:      w_d = bus.SHORT ? W1 : W2;
        W2:      w_d = bus.LONG  ? W3 : W1;
        default: w_d = W1;
      endcase
      if (bus.STOP && (w_d == W1)) run_d = 1'b0;

      if (bus.DRW) r_d[a_idx] = dbus;
      if (bus.LDC) c_d = alu_cout;
      if (bus.LDZ) z_d = (alu_f == 8'h00);

      if (bus.LPC)        pc_d = dbus[ADDR_W-1:0];
      else if (bus.PCADD) pc_d = pc_q + pc_offset;
      else if (bus.PCINC) pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

      if (bus.LAR)        ar_d = dbus[ADDR_W-1:0];
      else if (bus.ARINC) ar_d = ar_q + {{(ADDR_W-1){1'b0}}, 1'b1};

      if (bus.LIR) ir_d = mem_at_pc;
    end
  end

  always_ff @(posedge T3 or posedge CLR) begin
    if (CLR) begin
      for (int i = 0; i < 4; i++) r_q[i] <= 8'h00;
      pc_q  <= '0;
      ar_q  <= '0;
      ir_q  <= 8'h00;
      c_q   <= 1'b0;
      z_q   <= 1'b0;
      w_q   <= W1;
      run_q <= 1'b0;
    end else begin
      r_q   <= r_d;
      pc_q  <= pc_d;
      ar_q  <= ar_d;
      ir_q  <= ir_d;
      c_q   <= c_d;
      z_q   <= z_d;
      w_q   <= w_d;
      run_q <= run_d;
    end
  end

  // Memory keeps its contents across CLR; CLR only suppresses the pending write.
  always_ff @(posedge T3 or posedge CLR) begin
    if (CLR) begin
    end else if (run_q && bus.MEMW) begin
      mem_q[ar_q] <= dbus;
    end
  end

  assign bus.W       = w_q;
  assign bus.IR      = ir_q[7:4];
  assign bus.C       = c_q;
  assign bus.Z       = z_q;
  assign bus.IR_FULL = ir_q;
  assign bus.PC_OUT  = pc_q;
  assign bus.AR_OUT  = ar_q;
  assign bus.DBUS    = dbus;
  assign bus.A_OUT   = a_val;
  assign bus.B_OUT   = b_val;
  assign bus.RUN     = run_q;

endmodule
